// File: rtl/bpu_pkg.sv
// Shared types and constants for the branch predictor: instruction kinds,
// 2-bit direction counter encodings and the per-entry status fields.
package bpu_pkg;

    // Instruction kind reported by execute with each resolved instruction.
    typedef enum logic [1:0] {
        KIND_NONE = 2'b00,
        KIND_BR   = 2'b01,
        KIND_JAL  = 2'b10,
        KIND_JALR = 2'b11
    } kind_t;

    // 2-bit saturating direction counter; bit 1 is the taken prediction.
    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

    // Width-independent part of a table entry. The tag and target fields
    // depend on module parameters and live in their own parallel arrays.
    typedef struct packed {
        logic valid;
        logic jump;
        ctr_t ctr;
    } entry_meta_t;

    // Architectural direction of a resolved instruction.
    function automatic logic actual_taken(input kind_t kind, input logic taken);
        return ((kind == KIND_BR) && taken) || (kind == KIND_JAL) || (kind == KIND_JALR);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup, prediction, resolve and redirect signals between the
// pipeline (master) and the branch predictor (slave).
interface branch_predictor_if
    import bpu_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            f_valid;
    logic [XLEN-1:0] f_pc;

    logic            p_valid;
    logic            p_hit;
    logic            p_taken;
    logic [XLEN-1:0] p_target;

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    kind_t           r_kind;
    logic            r_taken;
    logic [XLEN-1:0] r_target;
    logic            r_pred_taken;
    logic [XLEN-1:0] r_pred_target;

    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic [31:0]     mispredict_cnt;

    modport master (
        output f_valid, f_pc,
        output r_valid, r_pc, r_kind, r_taken, r_target, r_pred_taken, r_pred_target,
        input  p_valid, p_hit, p_taken, p_target,
        input  redirect, redirect_pc, mispredict_cnt
    );

    modport slave (
        input  f_valid, f_pc,
        input  r_valid, r_pc, r_kind, r_taken, r_target, r_pred_taken, r_pred_target,
        output p_valid, p_hit, p_taken, p_target,
        output redirect, redirect_pc, mispredict_cnt
    );
endinterface

// File: rtl/bpu_sat_ctr.sv
// Next-state function of a 2-bit saturating direction counter.
module bpu_sat_ctr
    import bpu_pkg::*;
(
    input  ctr_t ctr,
    input  logic taken,
    output ctr_t ctr_next
);

    // Step toward strongly-taken or strongly-not-taken, holding at the ends.
    always_comb begin
        // NOTE: default assignment first so every path drives ctr_next and no latch is inferred.
        ctr_next = ctr;
        if (taken) begin
            if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Tagged direct-mapped BTB with 2-bit direction counters. Predicts the next
// PC one cycle after a fetch lookup, learns from resolved instructions and
// raises a registered one-cycle redirect on every misprediction.
module branch_predictor
    import bpu_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int XLEN    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_predictor_if.slave  bus
);

    localparam int IDX = $clog2(ENTRIES);

    typedef logic [IDX-1:0]   idx_t;
    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [XLEN-1:0]  addr_t;

    // Table storage: status, tag and target arrays indexed in parallel.
    entry_meta_t meta_q   [ENTRIES];
    tag_t        tag_q    [ENTRIES];
    addr_t       target_q [ENTRIES];

    logic [31:0] cnt_q;

    // Lookup side: everything is read from the current (pre-update) table.
    idx_t  f_idx;
    tag_t  f_tag;
    logic  f_hit;
    logic  f_taken;
    addr_t f_target;

    // Resolve side.
    idx_t  r_idx;
    tag_t  r_tag;
    logic  r_hit;
    logic  r_actual;
    logic  mispredict;
    addr_t fallthrough_pc;
    addr_t correct_pc;
    ctr_t  ctr_next;

    // Only the index and tag bit ranges of the PCs address the table.
    logic  unused_pc_bits;
    assign unused_pc_bits = ^{bus.f_pc, bus.r_pc};

    // Fetch-side table read and prediction.
    always_comb begin
        f_idx    = bus.f_pc[IDX+1:2];
        f_tag    = bus.f_pc[IDX+TAG_W+1:IDX+2];
        f_hit    = meta_q[f_idx].valid && (tag_q[f_idx] == f_tag);
        f_taken  = f_hit && (meta_q[f_idx].jump || meta_q[f_idx].ctr[1]);
        f_target = f_taken ? target_q[f_idx] : bus.f_pc + addr_t'(4);
    end

    // Resolve-side hit, actual direction and misprediction detection.
    always_comb begin
        r_idx          = bus.r_pc[IDX+1:2];
        r_tag          = bus.r_pc[IDX+TAG_W+1:IDX+2];
        r_hit          = meta_q[r_idx].valid && (tag_q[r_idx] == r_tag);
        r_actual       = actual_taken(bus.r_kind, bus.r_taken);
        fallthrough_pc = bus.r_pc + addr_t'(4);
        correct_pc     = r_actual ? bus.r_target : fallthrough_pc;
        mispredict     = (bus.r_pred_taken != r_actual) ||
                         (r_actual && (bus.r_pred_target != bus.r_target));
    end

    bpu_sat_ctr u_sat_ctr (
        .ctr      (meta_q[r_idx].ctr),
        .taken    (bus.r_taken),
        .ctr_next (ctr_next)
    );

    // Register the prediction; p_* fields hold while no lookup is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
        if (!rst_n) begin
            bus.p_valid  <= 1'b0;
            bus.p_hit    <= 1'b0;
            bus.p_taken  <= 1'b0;
            bus.p_target <= '0;
        end else begin
            bus.p_valid <= bus.f_valid;
            if (bus.f_valid) begin
                bus.p_hit    <= f_hit;
                bus.p_taken  <= f_taken;
                bus.p_target <= f_target;
            end
        end
    end

    // One-cycle redirect pulse carrying the correct next PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.redirect    <= 1'b0;
            bus.redirect_pc <= '0;
        end else begin
            bus.redirect <= bus.r_valid && mispredict;
            if (bus.r_valid && mispredict) bus.redirect_pc <= correct_pc;
        end
    end

    // Saturating misprediction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (bus.r_valid && mispredict && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign bus.mispredict_cnt = cnt_q;

    // Table training from resolved instructions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the table is flop-based, so it is cleared on reset like any other register.
            for (int i = 0; i < ENTRIES; i++) begin
                meta_q[i]   <= '{valid: 1'b0, jump: 1'b0, ctr: CTR_WNT};
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else if (bus.r_valid) begin
            case (bus.r_kind)
                KIND_BR: begin
                    if (r_hit) begin
                        meta_q[r_idx].ctr <= ctr_next;
                        if (bus.r_taken) target_q[r_idx] <= bus.r_target;
                    end else if (bus.r_taken) begin
                        meta_q[r_idx]   <= '{valid: 1'b1, jump: 1'b0, ctr: CTR_WT};
                        tag_q[r_idx]    <= r_tag;
                        target_q[r_idx] <= bus.r_target;
                    end
                end
                KIND_JAL, KIND_JALR: begin
                    meta_q[r_idx]   <= '{valid: 1'b1, jump: 1'b1, ctr: CTR_ST};
                    tag_q[r_idx]    <= r_tag;
                    target_q[r_idx] <= bus.r_target;
                end
                KIND_NONE: begin
                    // A non-control-flow instruction aliasing a live entry evicts it.
                    if (r_hit) meta_q[r_idx].valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor: drivers push expected
// predictions/redirects into queues, a negedge monitor pops and compares.
module tb_branch_predictor;
    import bpu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    branch_predictor_if #(.XLEN(32)) bus ();

    branch_predictor #(.ENTRIES(16), .TAG_W(8), .XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        hit;
        logic        taken;
        logic [31:0] target;
    } pred_exp_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] cnt;
    } redir_exp_t;

    pred_exp_t  pred_q  [$];
    redir_exp_t redir_q [$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every presented prediction/redirect with the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.p_valid) begin
                if (pred_q.size() == 0) begin
                    check("unexpected_p_valid", 1, 0);
                end else begin
                    pred_exp_t e;
                    e = pred_q.pop_front();
                    check("p_hit",    64'(bus.p_hit),    64'(e.hit));
                    check("p_taken",  64'(bus.p_taken),  64'(e.taken));
                    check("p_target", 64'(bus.p_target), 64'(e.target));
                end
            end
            if (bus.redirect) begin
                if (redir_q.size() == 0) begin
                    check("unexpected_redirect", 1, 0);
                end else begin
                    redir_exp_t r;
                    r = redir_q.pop_front();
                    check("redirect_pc",    64'(bus.redirect_pc),    64'(r.pc));
                    check("mispredict_cnt", 64'(bus.mispredict_cnt), 64'(r.cnt));
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic set_lookup(input logic [31:0] pc, input logic hit, input logic taken,
                              input logic [31:0] target);
        pred_exp_t e;
        bus.f_valid = 1'b1;
        bus.f_pc    = pc;
        e.hit = hit; e.taken = taken; e.target = target;
        pred_q.push_back(e);
    endtask

    task automatic set_resolve(input logic [31:0] pc, input kind_t kind, input logic taken,
                               input logic [31:0] target, input logic pred_taken,
                               input logic [31:0] pred_target, input logic exp_redirect,
                               input logic [31:0] exp_pc, input logic [31:0] exp_cnt);
        redir_exp_t r;
        bus.r_valid       = 1'b1;
        bus.r_pc          = pc;
        bus.r_kind        = kind;
        bus.r_taken       = taken;
        bus.r_target      = target;
        bus.r_pred_taken  = pred_taken;
        bus.r_pred_target = pred_target;
        if (exp_redirect) begin
            r.pc = exp_pc; r.cnt = exp_cnt;
            redir_q.push_back(r);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus.f_valid = 1'b0;
        bus.r_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_p_valid"},        64'(bus.p_valid),        0);
        check({tag, "_p_hit"},          64'(bus.p_hit),          0);
        check({tag, "_p_taken"},        64'(bus.p_taken),        0);
        check({tag, "_p_target"},       64'(bus.p_target),       0);
        check({tag, "_redirect"},       64'(bus.redirect),       0);
        check({tag, "_redirect_pc"},    64'(bus.redirect_pc),    0);
        check({tag, "_mispredict_cnt"}, 64'(bus.mispredict_cnt), 0);
    endtask

    initial begin
        bus.f_valid = 0; bus.f_pc = 0;
        bus.r_valid = 0; bus.r_pc = 0; bus.r_kind = KIND_NONE; bus.r_taken = 0;
        bus.r_target = 0; bus.r_pred_taken = 0; bus.r_pred_target = 0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Cold miss: fall-through prediction.
        set_lookup(32'h100, 0, 0, 32'h104); step();

        // Taken branch predicted not-taken: allocate with ctr=10.
        set_resolve(32'h100, KIND_BR, 1, 32'h200, 0, 32'h104, 1, 32'h200, 1); step();
        set_lookup(32'h100, 1, 1, 32'h200); step();

        // Two back-to-back not-taken resolves: 10 -> 01 -> 00.
        set_resolve(32'h100, KIND_BR, 0, 32'h200, 1, 32'h200, 1, 32'h104, 2); step();
        set_resolve(32'h100, KIND_BR, 0, 32'h200, 0, 32'h104, 0, 0, 0); step();
        set_lookup(32'h100, 1, 0, 32'h104); step();

        // Third not-taken holds at 00; one taken then only reaches 01.
        set_resolve(32'h100, KIND_BR, 0, 32'h200, 0, 32'h104, 0, 0, 0); step();
        set_resolve(32'h100, KIND_BR, 1, 32'h300, 0, 32'h104, 1, 32'h300, 3); step();
        set_lookup(32'h100, 1, 0, 32'h104); step();

        // Same-cycle lookup and update: lookup sees ctr=01, next sees ctr=10.
        set_lookup(32'h100, 1, 0, 32'h104);
        set_resolve(32'h100, KIND_BR, 1, 32'h300, 0, 32'h104, 1, 32'h300, 4); step();
        set_lookup(32'h100, 1, 1, 32'h300); step();

        // Correct taken prediction, then a wrong-target prediction.
        set_resolve(32'h100, KIND_BR, 1, 32'h300, 1, 32'h300, 0, 0, 0); step();
        set_resolve(32'h100, KIND_BR, 1, 32'h300, 1, 32'h2FC, 1, 32'h300, 5); step();

        // JAL at 0x140 (same index as 0x100, different tag).
        set_resolve(32'h140, KIND_JAL, 0, 32'h80, 0, 32'h144, 1, 32'h80, 6); step();
        set_lookup(32'h140, 1, 1, 32'h80); step();
        set_lookup(32'h100, 0, 0, 32'h104); step();
        set_lookup(32'h180, 0, 0, 32'h184); step();

        // Correctly predicted JALR allocates; outputs hold while idle.
        set_resolve(32'h144, KIND_JALR, 0, 32'h400, 1, 32'h400, 0, 0, 0); step();
        set_lookup(32'h144, 1, 1, 32'h400); step();
        step();
        check("hold_p_valid",  64'(bus.p_valid),  0);
        check("hold_p_taken",  64'(bus.p_taken),  1);
        check("hold_p_target", 64'(bus.p_target), 64'h400);

        // Non-control-flow predicted taken: redirect to pc+4 and evict.
        set_resolve(32'h144, KIND_NONE, 1, 32'h400, 1, 32'h400, 1, 32'h148, 7); step();
        set_lookup(32'h144, 0, 0, 32'h148); step();
        set_resolve(32'h148, KIND_NONE, 0, 32'h0, 0, 32'h14C, 0, 0, 0); step();

        // Fall-through wraps modulo 2^32.
        set_lookup(32'hFFFF_FFFC, 0, 0, 32'h0); step();

        // Counter saturation: preload all-ones, then two more mispredicts.
        @(negedge clk);
        #2;
        force dut.cnt_q = 32'hFFFF_FFFF;
        set_resolve(32'h200, KIND_NONE, 0, 32'h0, 1, 32'h0, 1, 32'h204, 32'hFFFF_FFFF); step();
        release dut.cnt_q;
        set_resolve(32'h200, KIND_NONE, 0, 32'h0, 1, 32'h0, 1, 32'h204, 32'hFFFF_FFFF); step();

        // Make outputs live, then assert reset mid-resolve.
        set_lookup(32'h140, 1, 1, 32'h80);
        set_resolve(32'h200, KIND_NONE, 0, 32'h0, 1, 32'h0, 1, 32'h204, 32'hFFFF_FFFF); step();
        set_resolve(32'h140, KIND_JAL, 0, 32'h999, 0, 32'h144, 0, 0, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        bus.r_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Table was cleared by reset.
        set_lookup(32'h140, 0, 0, 32'h144); step();

        repeat (3) @(posedge clk);
        check("pred_queue_drained",  64'(pred_q.size()),  0);
        check("redir_queue_drained", 64'(redir_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch predictor with a tagged, direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It is the sequential successor to the combinational branch resolver and sits beside fetch. It predicts the next PC one cycle after a fetch lookup. It takes resolved outcomes from execute, updates its tables, and raises a registered redirect on any misprediction.

## Interface
Parameters:
- `ENTRIES`, 16: BTB/counter entries; must be a power of two, ≥ 2. `IDX = log2(ENTRIES)`.
- `TAG_W`, 8: stored tag bits.
- `XLEN`, 32: address width.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `f_valid`  in  1  fetch lookup request.
- `f_pc`  in  XLEN  fetch PC.
- `p_valid`  out  1  prediction valid; this is `f_valid` delayed one cycle.
- `p_hit`  out  1  lookup hit a valid entry with a matching tag.
- `p_taken`  out  1  predicted taken.
- `p_target`  out  XLEN  predicted next PC.
- `r_valid`  in  1  resolve strobe from execute.
- `r_pc`  in  XLEN  resolved instruction PC.
- `r_kind`  in  2  instruction kind: 00 not control-flow, 01 conditional branch, 10 JAL, 11 JALR.
- `r_taken`  in  1  branch condition outcome; used only for kind 01.
- `r_target`  in  XLEN  computed target.
- `r_pred_taken`  in  1  prediction that travelled with the instruction.
- `r_pred_target`  in  XLEN  target that travelled with the instruction.
- `redirect`  out  1  one-cycle misprediction pulse.
- `redirect_pc`  out  XLEN  correct next PC.
- `mispredict_cnt`  out  32  saturating misprediction counter.

## Operation
- Index and tag:
  - index = `pc[IDX+1:2]`.
  - tag = `pc[IDX+TAG_W+1:IDX+2]`.
- Entry fields:
  - `valid`, `tag[TAG_W]`, `target[XLEN]`, `jump` (1 = JAL/JALR), `ctr[2]`.
- Lookup:
  - hit = valid & tag match.
  - `p_taken` = hit & (jump | ctr[1]).
  - `p_target` = `p_taken` ? target : `f_pc`+4. Addition wraps modulo 2^XLEN.
- Actual outcome:
  - actual_taken = (kind 01 & `r_taken`) | kind 10 | kind 11. Kind 00 is never taken.
- Misprediction (only while `r_valid`):
  - `r_pred_taken` ≠ actual_taken, or
  - actual_taken & `r_pred_target` ≠ `r_target`.
  - Kind 00 predicted taken is a misprediction; its `redirect_pc` is `r_pc`+4.
- Update (only while `r_valid`):
  - Kind 01, hit: ctr increments on taken and decrements on not-taken, saturating at 11/00. Target is rewritten on taken.
  - Kind 01, miss, taken: allocate; ctr = 10, jump = 0.
  - Kind 01, miss, not taken: no write.
  - Kind 10/11: allocate or overwrite; jump = 1, ctr = 11, target = `r_target`.
  - Kind 00, hit: invalidate the entry (aliasing cleanup). Kind 00, miss: no write.
- Redirect:
  - `redirect_pc` = actual_taken ? `r_target` : `r_pc`+4.
- `mispredict_cnt`:
  - +1 per mispredict; holds at 0xFFFF_FFFF.

## Timing
- Reset (asynchronous, any cycle including mid-update) sets:
  - all valid bits = 0, all ctr = 01;
  - `p_valid`/`p_hit`/`p_taken` = 0, `p_target` = 0;
  - `redirect` = 0, `redirect_pc` = 0, `mispredict_cnt` = 0.
- Lookup latency is 1 cycle. Table read is registered on `f_valid`. When `f_valid` = 0, `p_*` outputs hold their previous values and `p_valid` = 0.
- Redirect latency is 1 cycle after `r_valid`. `redirect` is high for exactly one cycle per mispredict.
- Table write takes effect at the edge following `r_valid`.
- Simultaneous lookup and update to the same index in one cycle: the lookup returns pre-update contents (read-before-write). There is no bypass.
- Back-to-back `r_valid` to the same index: each update sees the previous one's result.
- No stall or backpressure: both ports accept every cycle.

## Structure
- Shared package `bpu_pkg`:
  - `r_kind` encodings (`KIND_NONE`, `KIND_BR`, `KIND_JAL`, `KIND_JALR`);
  - counter constants (`CTR_SNT`=00, `CTR_WNT`=01, `CTR_WT`=10, `CTR_ST`=11);
  - a packed entry typedef.
- One sub-module, `bpu_sat_ctr`: combinational 2-bit saturating next-state function (ctr, taken → ctr').
- Tables are flip-flop arrays, so reset clears them. No SRAM macro.

## Test plan
- Reset, then lookup `f_pc`=0x100 → next cycle `p_valid`=1, `p_hit`=0, `p_taken`=0, `p_target`=0x104.
- Resolve kind 01 at 0x100, taken, target 0x200, predicted not-taken → `redirect`=1 with `redirect_pc`=0x200, `mispredict_cnt`=1. A later lookup 0x100 gives `p_hit`=1, `p_taken`=1 (ctr 10), `p_target`=0x200.
- Two not-taken resolves at 0x100 → ctr 00. Lookup gives `p_taken`=0, `p_target`=0x104. A third not-taken resolve leaves ctr at 00 (saturation).
- JAL at 0x140, target 0x80 → lookup 0x140 gives `p_taken`=1, `p_target`=0x80. A 0x140+(ENTRIES·4) lookup with a different tag gives `p_hit`=0.
- Resolve and lookup of 0x100 in the same cycle → lookup returns old entry contents. The next lookup returns the updated contents.
- Force 2^32−1 mispredicts (preload via hierarchical force) plus one more → `mispredict_cnt` stays 0xFFFF_FFFF. Assert `rst_n` low mid-resolve → every output reads its reset value immediately.
